// File: rtl/ram_arbiter.sv
// Four-way SRAM arbiter: one fixed-length (LAT cycle) access at a time, one-cycle ack on completion.
// Define RAM_ARB_RR_EN to rotate priority among requesters 1..3; requester 0 always wins.
module ram_arbiter #(
    parameter int LAT = 3
) (
    input  logic        clk_sys,
    input  logic        nRESET,
    input  logic [3:0]  req,
    input  logic [3:0]  we,
    input  logic [99:0] addr,
    input  logic [31:0] din,
    output logic [3:0]  ack,
    output logic [7:0]  rdata,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic [24:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    output logic        ram_rd,
    input  logic [7:0]  ram_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic [1:0] win;

`ifdef RAM_ARB_RR_EN
    logic [1:0] rr_ptr;
    logic [2:0] rr_pos;
    logic       rr_found;

    // Search 1..3 starting just after the last granted requester in that group.
    always_comb begin
        win      = 2'd0;
        rr_pos   = 3'd0;
        rr_found = 1'b0;
        if (!req[0]) begin
            for (int o = 1; o <= 3; o++) begin
                rr_pos = {1'b0, rr_ptr} + 3'(o);
                if (rr_pos > 3'd3)
                    rr_pos = rr_pos - 3'd3;
                if (!rr_found && req[rr_pos[1:0]]) begin
                    win      = rr_pos[1:0];
                    rr_found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET)
            rr_ptr <= 2'd3;
        else if (state == IDLE && req != 4'd0 && win != 2'd0)
            rr_ptr <= win;
    end
`else
    always_comb begin
        if (req[0])
            win = 2'd0;
        else if (req[1])
            win = 2'd1;
        else if (req[2])
            win = 2'd2;
        else
            win = 2'd3;
    end
`endif

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req != 4'd0) next_state = ACCESS;
            ACCESS:  if (cnt == 4'd1) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ram_we still carries the latched direction on the final ACCESS edge, so it selects rdata capture.
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            cnt      <= 4'd0;
            grant_id <= 2'd0;
            ram_addr <= 25'd0;
            ram_din  <= 8'd0;
            ram_we   <= 1'b0;
            ram_rd   <= 1'b0;
            ack      <= 4'd0;
            rdata    <= 8'd0;
        end else begin
            ack <= 4'd0;
            case (state)
                IDLE: begin
                    if (req != 4'd0) begin
                        grant_id <= win;
                        ram_addr <= addr[int'(win)*25 +: 25];
                        ram_din  <= din[int'(win)*8 +: 8];
                        ram_we   <= we[win];
                        ram_rd   <= ~we[win];
                        cnt      <= 4'(LAT);
                    end
                end
                ACCESS: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        ram_we        <= 1'b0;
                        ram_rd        <= 1'b0;
                        ack[grant_id] <= 1'b1;
                        if (!ram_we)
                            rdata <= ram_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed requests push expected acks, a forked monitor pops them.
// The memory model echoes writes and otherwise returns addr[7:0]^8'h3C (8'h5C at 25'h0A000).
module tb_ram_arbiter;

    localparam int LAT = 3;

    typedef struct {
        logic [3:0] ack;
        logic [1:0] id;
        logic [7:0] rd;
    } exp_t;

    logic        clk_sys = 1'b0;
    logic        nRESET;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [99:0] addr;
    logic [31:0] din;
    logic [3:0]  ack;
    logic [7:0]  rdata;
    logic [1:0]  grant_id;
    logic        busy;
    logic [24:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        ram_rd;
    logic [7:0]  ram_dout = 8'h00;

    exp_t       sb[$];
    logic [3:0] auto_drop;
    logic [7:0] mem [logic [24:0]];
    int         n_cmp = 0;
    int         n_fail = 0;

    ram_arbiter #(.LAT(LAT)) dut (
        .clk_sys  (clk_sys),
        .nRESET   (nRESET),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .ack      (ack),
        .rdata    (rdata),
        .grant_id (grant_id),
        .busy     (busy),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_rd   (ram_rd),
        .ram_dout (ram_dout)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (ram_we)
            mem[ram_addr] = ram_din;
    end

    always @(negedge clk_sys) begin
        if (mem.exists(ram_addr))
            ram_dout = mem[ram_addr];
        else if (ram_addr == 25'h0A000)
            ram_dout = 8'h5C;
        else
            ram_dout = ram_addr[7:0] ^ 8'h3C;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_cmp++;
        if (actual !== required) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, required);
        end
    endtask

    task automatic push_expect(input logic [1:0] id, input logic [7:0] rd);
        exp_t e;
        e.ack = 4'b0001 << id;
        e.id  = id;
        e.rd  = rd;
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input int idx, input logic wr, input logic [24:0] a,
                                  input logic [7:0] d, input logic drop);
        addr[idx*25 +: 25] = a;
        din[idx*8 +: 8]    = d;
        we[idx]            = wr;
        auto_drop[idx]     = drop;
        req[idx]           = 1'b1;
    endtask

    // Requesters that auto-drop release req in the cycle their ack is visible.
    task automatic tick();
        @(posedge clk_sys);
        #1;
        for (int i = 0; i < 4; i++)
            if (ack[i] && auto_drop[i])
                req[i] = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || req != 4'd0) && n < budget) begin
            tick();
            n++;
        end
        check_output("drain_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk_sys);
            if (ack != 4'd0) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_output("ack_vector", 32'(ack), 32'(e.ack));
                    check_output("ack_grant_id", 32'(grant_id), 32'(e.id));
                    check_output("ack_rdata", 32'(rdata), 32'(e.rd));
                    check_output("ack_busy", 32'(busy), 32'd1);
                end
            end
        end
    endtask

    initial begin
        nRESET    = 1'b0;
        req       = 4'd0;
        we        = 4'd0;
        addr      = '0;
        din       = '0;
        auto_drop = 4'd0;
        fork
            monitor_loop();
        join_none

        tick();
        tick();
        check_output("rst_ram_we", 32'(ram_we), 32'd0);
        check_output("rst_ram_rd", 32'(ram_rd), 32'd0);
        check_output("rst_ram_addr", 32'(ram_addr), 32'd0);
        check_output("rst_ram_din", 32'(ram_din), 32'd0);
        check_output("rst_ack", 32'(ack), 32'd0);
        check_output("rst_rdata", 32'(rdata), 32'd0);
        check_output("rst_grant_id", 32'(grant_id), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);

        // cpu read right at reset release; arbitration on the first edge after release
        $display("[TB] cpu read after reset release");
        nRESET = 1'b1;
        apply_stimulus(3, 1'b0, 25'h0A000, 8'h00, 1'b1);
        push_expect(2'd3, 8'h5C);
        tick();
        check_output("c1_grant_id", 32'(grant_id), 32'd3);
        check_output("c1_ram_addr", 32'(ram_addr), 32'h0A000);
        check_output("c1_ram_we", 32'(ram_we), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            check_output($sformatf("cpu_rd_cycle%0d", c), 32'(ram_rd), 32'd1);
            check_output($sformatf("cpu_busy_cycle%0d", c), 32'(busy), 32'd1);
            tick();
        end
        check_output("c4_ram_rd", 32'(ram_rd), 32'd0);
        check_output("c4_ack", 32'(ack), 32'h8);
        check_output("c4_rdata", 32'(rdata), 32'h5C);
        tick();
        check_output("c5_busy", 32'(busy), 32'd0);
        drain(50);

        $display("[TB] simultaneous requests 4'b1111 then 4'b1110");
        apply_stimulus(0, 1'b0, 25'h000011, 8'h00, 1'b1);
        apply_stimulus(1, 1'b0, 25'h000022, 8'h00, 1'b1);
        apply_stimulus(2, 1'b0, 25'h000033, 8'h00, 1'b1);
        apply_stimulus(3, 1'b0, 25'h000044, 8'h00, 1'b1);
        push_expect(2'd0, 8'h2D);
        push_expect(2'd1, 8'h1E);
        push_expect(2'd2, 8'h0F);
        push_expect(2'd3, 8'h78);
        drain(100);
        apply_stimulus(1, 1'b0, 25'h000022, 8'h00, 1'b1);
        apply_stimulus(2, 1'b0, 25'h000033, 8'h00, 1'b1);
        apply_stimulus(3, 1'b0, 25'h000044, 8'h00, 1'b1);
        push_expect(2'd1, 8'h1E);
        push_expect(2'd2, 8'h0F);
        push_expect(2'd3, 8'h78);
        drain(100);

        $display("[TB] dma write with tape waiting");
        apply_stimulus(0, 1'b1, 25'h181FFF, 8'hA5, 1'b1);
        apply_stimulus(1, 1'b0, 25'h181FFF, 8'h00, 1'b1);
        push_expect(2'd0, 8'h78);
        push_expect(2'd1, 8'hA5);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check_output($sformatf("dma_we_cycle%0d", c), 32'(ram_we), 32'd1);
            check_output($sformatf("dma_rd_cycle%0d", c), 32'(ram_rd), 32'd0);
            check_output($sformatf("dma_addr_cycle%0d", c), 32'(ram_addr), 32'h181FFF);
            check_output($sformatf("dma_din_cycle%0d", c), 32'(ram_din), 32'hA5);
        end
        tick();
        check_output("dma_done_we", 32'(ram_we), 32'd0);
        check_output("dma_rdata_kept", 32'(rdata), 32'h78);
        tick();
        check_output("dma_idle_busy", 32'(busy), 32'd0);
        tick();
        check_output("tape_grant_busy", 32'(busy), 32'd1);
        check_output("tape_grant_id", 32'(grant_id), 32'd1);
        check_output("tape_grant_rd", 32'(ram_rd), 32'd1);
        drain(50);

        $display("[TB] dma arrives during cpu access");
        apply_stimulus(3, 1'b0, 25'h000044, 8'h00, 1'b1);
        push_expect(2'd3, 8'h78);
        tick();
        tick();
        apply_stimulus(0, 1'b0, 25'h000011, 8'h00, 1'b1);
        push_expect(2'd0, 8'h2D);
        check_output("nopreempt_c2_id", 32'(grant_id), 32'd3);
        tick();
        check_output("nopreempt_c3_id", 32'(grant_id), 32'd3);
        tick();
        check_output("nopreempt_c4_rd", 32'(ram_rd), 32'd0);
        tick();
        check_output("nopreempt_c5_busy", 32'(busy), 32'd0);
        tick();
        check_output("dma_after_cpu_busy", 32'(busy), 32'd1);
        check_output("dma_after_cpu_id", 32'(grant_id), 32'd0);
        drain(50);

        $display("[TB] cpu req held one cycle past ack");
        apply_stimulus(3, 1'b0, 25'h000033, 8'h00, 1'b0);
        push_expect(2'd3, 8'h0F);
        push_expect(2'd3, 8'h0F);
        repeat (4) tick();
        tick();
        check_output("rereq_idle_busy", 32'(busy), 32'd0);
        tick();
        check_output("rereq_busy", 32'(busy), 32'd1);
        check_output("rereq_id", 32'(grant_id), 32'd3);
        check_output("rereq_rd", 32'(ram_rd), 32'd1);
        req[3] = 1'b0;
        drain(50);

        $display("[TB] reset during access");
        apply_stimulus(3, 1'b0, 25'h0A000, 8'h00, 1'b1);
        tick();
        tick();
        check_output("abort_pre_rd", 32'(ram_rd), 32'd1);
        #2;
        nRESET = 1'b0;
        req    = 4'd0;
        #1;
        check_output("abort_ram_rd", 32'(ram_rd), 32'd0);
        check_output("abort_ram_we", 32'(ram_we), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_ack", 32'(ack), 32'd0);
        check_output("abort_rdata", 32'(rdata), 32'd0);
        check_output("abort_grant_id", 32'(grant_id), 32'd0);
        tick();
        tick();
        nRESET = 1'b1;
        repeat (3) tick();
        check_output("post_abort_busy", 32'(busy), 32'd0);
        check_output("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL provide parameter LAT, default 3: RAM access length in clk_sys cycles. Legal range 1..15.
REQ-002 SHALL provide port clk_sys, input, 1: single system clock. All state changes on its rising edge.
REQ-003 SHALL provide port nRESET, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL provide port req, input, 4: access requests. Bit 0 dma/ioctl, bit 1 tape, bit 2 fdd, bit 3 cpu.
REQ-005 SHALL provide port we, input, 4: per-requester write select. 1 means write, 0 means read.
REQ-006 SHALL provide port addr, input, 100: per-requester address. Requester n occupies bits [25n+24:25n].
REQ-007 SHALL provide port din, input, 32: per-requester write data. Requester n occupies bits [8n+7:8n].
REQ-008 SHALL provide port ack, output, 4: one-cycle completion pulse for each requester.
REQ-009 SHALL provide port rdata, output, 8: data captured by the last completed read.
REQ-010 SHALL provide port grant_id, output, 2: index of the current or most recent winner.
REQ-011 SHALL provide port busy, output, 1: high while an access is in progress.
REQ-012 SHALL provide ports ram_addr (output, 25), ram_din (output, 8), ram_we (output, 1), ram_rd (output, 1) and ram_dout (input, 8), connecting to the sram block.

Function
REQ-013 SHALL implement the states IDLE, ACCESS and DONE.
REQ-014 IDLE: on an edge where req is nonzero, the arbiter SHALL:
- pick the winner;
- latch the winner's addr, din and we plus its index into grant_id;
- load the cycle counter with LAT;
- go to ACCESS.
With no request it SHALL stay in IDLE.
REQ-015 ACCESS: behaviour SHALL be as follows.
- ram_addr and ram_din hold the latched values, stable for the whole state.
- If the latched we is 1, ram_we is 1 and ram_rd is 0; otherwise ram_rd is 1 and ram_we is 0.
- The counter decrements once per cycle.
- When the counter reaches 1, the state goes to DONE.
REQ-016 DONE: the arbiter SHALL:
- drop ram_we and ram_rd;
- pulse ack[grant_id] for exactly one cycle;
- for a read, load rdata with the ram_dout sampled at the last ACCESS edge;
- go unconditionally to IDLE.
REQ-017 Timing: a request sampled at edge 0 SHALL give ACCESS for cycles 1..LAT and ack in cycle LAT+1. The next grant SHALL come no earlier than edge LAT+2.
REQ-018 rdata SHALL hold its value until the next read's DONE. Writes SHALL leave rdata unchanged.
REQ-019 busy SHALL be 1 in ACCESS and DONE, and 0 in IDLE.
REQ-020 Default priority SHALL be fixed: bit 0 > 1 > 2 > 3.
REQ-021 There SHALL be no preemption. A higher-priority request arriving during ACCESS or DONE waits for IDLE.
REQ-022 A request dropped during ACCESS SHALL NOT abort the access. ack is still pulsed.
REQ-023 A requester SHALL drop req in the cycle it sees ack. A req still high in the following IDLE cycle is a new access.
REQ-024 A request arriving in the same cycle as a DONE SHALL be ignored until IDLE.
REQ-025 LAT outside 1..15 is illegal. Behaviour for such values is undefined and not verified.

Reset
REQ-026 While nRESET is low, the block SHALL immediately and asynchronously:
- force state IDLE;
- set ram_we=0, ram_rd=0, ram_addr=0, ram_din=0;
- set ack=0, rdata=0, grant_id=0, busy=0;
- set the counter to 0 and the round-robin pointer to 3.
REQ-027 Reset asserted during ACCESS SHALL abort the access with no ack. The aborted requester SHALL be served again only if its req is high after release.
REQ-028 The first arbitration SHALL happen on the first rising edge after nRESET goes high.

Configuration
REQ-029 Macro RAM_ARB_RR_EN SHALL control the arbitration policy.
- Defined: bit 0 stays absolute top priority. Bits 1..3 rotate round-robin: the granted requester in 1..3 becomes lowest priority, and the pointer updates on entry to ACCESS.
- Undefined: fixed priority per REQ-020, and the pointer logic is absent.

Verification
REQ-030 Bench SHALL drive reset release, then cpu read only (req=4'b1000, addr3=25'h0A000, memory model returns 8'h5C), with LAT=3. Required: ram_rd high in cycles 1..3, ack=4'b1000 in cycle 4, rdata=8'h5C.
REQ-031 Bench SHALL drive simultaneous req=4'b1111 with requesters dropping req on ack. Required without macro: grant order 0,1,2,3. Required with macro after pointer=3: grant order 0,1,2,3, then re-request of 4'b1110 grants 1,2,3.
REQ-032 Bench SHALL drive a dma write (addr0=25'h181FFF, din0=8'hA5) while tape holds req. Required: ram_we high for 3 cycles with ram_addr=25'h181FFF and ram_din=8'hA5, tape granted at the edge after dma's DONE, rdata unchanged.
REQ-033 Bench SHALL raise req bit 0 in cycle 2 of a cpu ACCESS. Required: cpu completes with ack=4'b1000, and dma is granted at the next IDLE edge.
REQ-034 Bench SHALL pull nRESET low in ACCESS cycle 2. Required: ram_rd and ram_we drop without waiting for a clock edge, no ack pulse occurs, and busy=0.
REQ-035 Bench SHALL hold cpu req high for one cycle after ack. Required: a second cpu access starts at edge LAT+2.
